// File: rtl/gpio_input_conditioner_if.sv
// Register-file side bundle of the GPIO input conditioner: pad levels and
// configuration flow in, conditioned levels, edge pulses and interrupt flags flow out.
interface gpio_input_conditioner_if #(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 16,
  parameter int DB_CNT_W   = 4
);
  logic [WIDTH-1:0]      gpio_data_in;
  logic [PRESCALE_W-1:0] db_prescale;
  logic [DB_CNT_W-1:0]   db_threshold;
  logic [WIDTH-1:0]      irq_rise_en;
  logic [WIDTH-1:0]      irq_fall_en;
  logic [WIDTH-1:0]      irq_clr;
  logic [WIDTH-1:0]      gpio_in_sync;
  logic [WIDTH-1:0]      rise_pulse;
  logic [WIDTH-1:0]      fall_pulse;
  logic [WIDTH-1:0]      irq_status;
  logic                  irq;

  modport master (
    output gpio_data_in, db_prescale, db_threshold, irq_rise_en, irq_fall_en, irq_clr,
    input  gpio_in_sync, rise_pulse, fall_pulse, irq_status, irq
  );

  modport slave (
    input  gpio_data_in, db_prescale, db_threshold, irq_rise_en, irq_fall_en, irq_clr,
    output gpio_in_sync, rise_pulse, fall_pulse, irq_status, irq
  );
endinterface

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: 2-flop synchroniser, optional per-pin debounce
// (enabled by defining GPIO_IN_DEBOUNCE_EN), edge detection and sticky interrupt flags.
module gpio_input_conditioner #(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 16,
  parameter int DB_CNT_W   = 4
) (
  input logic                    sys_clk,
  input logic                    sys_rst,
  gpio_input_conditioner_if.slave bus
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] irq_status_q;
  logic [WIDTH-1:0] irq_status_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

`ifdef GPIO_IN_DEBOUNCE_EN
  logic [PRESCALE_W-1:0] pcnt_q;
  logic                  tick;
  logic [DB_CNT_W-1:0]   thr_last;

  // Using >= rather than == makes a lowered prescale wrap on the next cycle.
  assign tick     = (pcnt_q >= bus.db_prescale);
  assign thr_last = (bus.db_threshold == '0) ? '0 : bus.db_threshold - 1'b1;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      pcnt_q <= '0;
    end else if (tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_db
      logic [DB_CNT_W-1:0] dcnt_q;
      logic [DB_CNT_W-1:0] dcnt_d;
      logic                differ;
      logic                accept;

      assign differ = sync2_q[gi] ^ stable_q[gi];
      assign accept = differ & tick & (dcnt_q == thr_last);
      assign stable_d[gi] = accept ? sync2_q[gi] : stable_q[gi];

      always_comb begin
        dcnt_d = dcnt_q;
        if (!differ) begin
          dcnt_d = '0;
        end else if (tick) begin
          dcnt_d = accept ? '0 : dcnt_q + 1'b1;
        end
      end

      always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
          dcnt_q <= '0;
        end else begin
          dcnt_q <= dcnt_d;
        end
      end
    end
  endgenerate
`else
  // Debounce configuration inputs have no function in this build.
  logic unused_db_cfg;
  assign unused_db_cfg = ^{bus.db_prescale, bus.db_threshold};
  assign stable_d      = sync2_q;
`endif

  assign rise = stable_q & ~stable_dly_q;
  assign fall = ~stable_q & stable_dly_q;

  // Set is OR-ed in after the clear mask so a same-cycle event wins.
  assign irq_status_d = (irq_status_q & ~bus.irq_clr)
                      | (rise & bus.irq_rise_en)
                      | (fall & bus.irq_fall_en);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      irq_status_q <= '0;
    end else begin
      sync1_q      <= bus.gpio_data_in;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      irq_status_q <= irq_status_d;
    end
  end

  assign bus.gpio_in_sync = stable_q;
  assign bus.rise_pulse   = rise;
  assign bus.fall_pulse   = fall;
  assign bus.irq_status   = irq_status_q;
  assign bus.irq          = |irq_status_q;

endmodule

// File: doc/gpio_input_conditioner.md
# gpio_input_conditioner

Input conditioning stage directly downstream of the GPIO pad interface. It consumes the raw `gpio_data_in` bus sampled from the pads and does three things: synchronises it into `sys_clk`, optionally debounces each pin, and detects rising and falling edges. Edge events feed a sticky, per-pin interrupt status register. Its outputs go to the GPIO register file, which handles read-back and interrupt reporting.

## Interface
Parameters:
- `WIDTH`, 32 — number of GPIO pins.
- `PRESCALE_W`, 16 — width of the debounce tick prescaler.
- `DB_CNT_W`, 4 — width of the per-pin debounce counter.

Ports:
- `sys_clk`  in  1  — single clock for all logic.
- `sys_rst`  in  1  — synchronous reset, active-low; sampled on the `sys_clk` rising edge.
- `gpio_data_in`  in  WIDTH  — raw pad input levels, asynchronous to `sys_clk`.
- `db_prescale`  in  PRESCALE_W  — debounce tick period minus 1.
- `db_threshold`  in  DB_CNT_W  — consecutive differing ticks required to accept a new level; 0 is treated as 1.
- `irq_rise_en`  in  WIDTH  — per-pin enable for rising-edge interrupts.
- `irq_fall_en`  in  WIDTH  — per-pin enable for falling-edge interrupts.
- `irq_clr`  in  WIDTH  — per-pin write-1-to-clear pulse for `irq_status`.
- `gpio_in_sync`  out  WIDTH  — conditioned (stable) pin levels.
- `rise_pulse`  out  WIDTH  — one-cycle pulse on a conditioned 0→1 transition.
- `fall_pulse`  out  WIDTH  — one-cycle pulse on a conditioned 1→0 transition.
- `irq_status`  out  WIDTH  — sticky per-pin interrupt flags.
- `irq`  out  1  — OR-reduction of `irq_status`.

## Operation
- **Synchroniser.** Two flops per pin: `sync1 <= gpio_data_in`, then `sync2 <= sync1`.
- **Prescaler.**
  - `pcnt` increments every cycle.
  - When `pcnt >= db_prescale`: `tick = 1` that cycle and `pcnt <= 0`.
  - `db_prescale = 0` gives a tick every cycle.
  - Lowering `db_prescale` below the current `pcnt` forces a tick and wrap on the next cycle.
- **Debounce** (per pin, counter `dcnt`, stable level `stable`):
  - If `sync2 == stable`: `dcnt <= 0`.
  - Else, on a tick:
    - if `dcnt == max(db_threshold,1) - 1`: `stable <= sync2` and `dcnt <= 0`;
    - otherwise `dcnt <= dcnt + 1`.
  - Else (no tick): hold.
  - A glitch that reverts before acceptance clears `dcnt`; no edge is produced.
- **Edge detection.**
  - `stable_d <= stable`.
  - `rise_pulse = stable & ~stable_d` and `fall_pulse = ~stable & stable_d`, both combinational from registers.
  - Each pulse is exactly one cycle wide.
- **Interrupt status.**
  - Set term: `set = (rise_pulse & irq_rise_en) | (fall_pulse & irq_fall_en)`.
  - Update: `irq_status <= (irq_status & ~irq_clr) | set`.
  - Set wins over a simultaneous clear on the same bit.
  - Changing an enable never clears an existing flag.
- **Outputs.** `gpio_in_sync = stable`; `irq = |irq_status`, combinational.
- **Reset behaviour.**
  - While `sys_rst = 0` at a clock edge, all registers go to 0: `sync1`, `sync2`, `pcnt`, `dcnt`, `stable`, `stable_d`, `irq_status`.
  - Every output is therefore 0 during and after reset.
  - A pin held high through reset produces one `rise_pulse` after the normal latency; software enables interrupts after reset.
  - Reset asserted mid-debounce discards the count.

## Timing
- E0 is the first `sys_clk` edge that samples a new `gpio_data_in` level.
- Without debounce (or with threshold 1 and prescale 0):
  - `sync2` updates at E1.
  - `stable` / `gpio_in_sync` update at E2.
  - `rise_pulse` / `fall_pulse` are high from E2 to E3.
  - `irq_status` and `irq` are set at E3.
- With debounce, prescale 0, threshold T: `stable` updates at E(1+T); the pulse and `irq_status` follow 1 and 2 edges later respectively.
- With prescale P: each count step waits for a tick, so acceptance takes T ticks, up to T·(P+1) cycles.

## Configuration
- Macro: `GPIO_IN_DEBOUNCE_EN`.
- **Defined:** prescaler and per-pin debounce counters are present, as described above.
- **Undefined:**
  - Prescaler and `dcnt` are not instantiated; `stable <= sync2` every cycle.
  - `db_prescale` and `db_threshold` remain as ports but are ignored.
  - Latency is the fixed no-debounce value.

## Test plan
- **Reset.** Hold `sys_rst = 0` for 3 cycles with `gpio_data_in = 32'hFFFFFFFF` → all outputs 0. Release → `rise_pulse = 32'hFFFFFFFF` for one cycle.
- **Basic edge.**
  - Setup: prescale 0, threshold 1, `irq_rise_en = 32'h1`.
  - Stimulus: pin 0 goes 0→1.
  - Response: `gpio_in_sync[0] = 1` at E2, `rise_pulse[0]` for one cycle, `irq = 1` at E3.
- **Glitch rejection.**
  - Setup: prescale 3, threshold 4.
  - Stimulus: a 10-cycle high pulse on pin 5 → no `rise_pulse`, `gpio_in_sync[5]` stays 0.
  - Stimulus: hold pin 5 high → `gpio_in_sync[5] = 1` after at most 17 cycles.
- **Fall interrupt and clear.**
  - Setup: `irq_fall_en = 32'h80000000`.
  - Stimulus: pin 31 goes 1→0 → `irq_status = 32'h80000000`.
  - Stimulus: pulse `irq_clr = 32'h80000000` → `irq_status = 0`, `irq = 0`.
- **Simultaneous set and clear.** `irq_clr[3]` is asserted in the same cycle that `rise_pulse[3] & irq_rise_en[3]` sets the flag → `irq_status[3]` remains 1.
- **Macro off.** Build without `GPIO_IN_DEBOUNCE_EN`, with `db_threshold = 15` and `db_prescale = 1000` → a 1-cycle glitch on pin 7 produces both `rise_pulse[7]` and `fall_pulse[7]`, at the E2 latency.
